// File: rtl/dcache_wt.sv
// -----------------------------------------------------------------------------
// dcache_wt
//
// Direct-mapped, write-through, no-write-allocate data cache for the MW stage
// of the pipelined MIPS machine. Each of the 2^INDEX_BITS lines holds a single
// 32-bit word together with its valid bit and tag. Loads that hit return data
// combinationally with no stall. Load misses and all stores go out to a
// variable-latency backing memory over a req/ack handshake. While such a
// transaction is outstanding, stall_o freezes the pipeline.
//
// Ports
//   clk_i          : clock; all state updates on the rising edge
//   reset_i        : asynchronous, active-high reset of all state
//   addr_i         : byte address from the ALU (bits [1:0] ignored)
//   wr_data_i      : store data
//   mem_read_i     : load request
//   mem_write_i    : store request (wins over mem_read_i)
//   rd_data_o      : load data (combinational)
//   stall_o        : combinational pipeline freeze
//   mem_req_o      : registered backing-memory request
//   mem_we_o       : registered request direction, 1 = write
//   mem_addr_o     : registered word address
//   mem_wdata_o    : registered write data
//   mem_rdata_i    : backing-memory read data, valid with mem_ack_i
//   mem_ack_i      : one-cycle completion pulse from the backing memory
//   hit_count_o    : number of completed load hits (wraps)
//   miss_count_o   : number of load misses (wraps)
// -----------------------------------------------------------------------------
module dcache_wt #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  output logic [31:0] rd_data_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [29:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  hit_s;
  logic                  stall_s;
  logic [31:0]           rd_data_s;
  logic                  line_fill_s;
  logic                  line_upd_s;
  logic [31:0]           line_wdata_s;
  logic                  unused_s;

  assign index_s  = addr_i[INDEX_BITS+1:2];
  assign tag_s    = addr_i[31:INDEX_BITS+2];
  assign hit_s    = valid_q[index_s] && (tag_q[index_s] == tag_s);
  // The byte offset within the word carries no information for a word cache.
  assign unused_s = ^addr_i[1:0];

  // Next-state, handshake, counter and line-update decode.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    stall_s      = 1'b0;
    rd_data_s    = 32'd0;
    line_fill_s  = 1'b0;
    line_upd_s   = 1'b0;
    line_wdata_s = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (mem_write_i) begin
          // Write-through: every store goes to memory; a read in the same
          // cycle is dropped.
          stall_s     = 1'b1;
          state_d     = ST_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_i[31:2];
          mem_wdata_d = wr_data_i;
        end else if (mem_read_i) begin
          if (hit_s) begin
            rd_data_s   = data_q[index_s];
            hit_count_d = hit_count_q + 32'd1;
          end else begin
            stall_s      = 1'b1;
            state_d      = ST_FILL;
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b0;
            mem_addr_d   = addr_i[31:2];
            miss_count_d = miss_count_q + 32'd1;
          end
        end else begin
          stall_s   = 1'b0;
          rd_data_s = 32'd0;
        end
      end

      ST_FILL: begin
        stall_s = !mem_ack_i;
        if (mem_ack_i) begin
          // Bypass the returning word so the load completes in the ack cycle.
          rd_data_s    = mem_rdata_i;
          line_fill_s  = 1'b1;
          line_wdata_s = mem_rdata_i;
          mem_req_d    = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          rd_data_s = 32'd0;
        end
      end

      ST_WRITE: begin
        stall_s = !mem_ack_i;
        if (mem_ack_i) begin
          // No allocate: only a line already holding this address is updated.
          line_upd_s   = hit_s;
          line_wdata_s = wr_data_i;
          mem_req_d    = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          line_upd_s = 1'b0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control state, backing-memory request registers and counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 30'd0;
      mem_wdata_q  <= 32'd0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Cache line storage: valid/tag set on fill, data on fill or store hit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= {LINES{1'b0}};
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= {TAG_BITS{1'b0}};
        data_q[i] <= 32'd0;
      end
    end else begin
      if (line_fill_s) begin
        valid_q[index_s] <= 1'b1;
        tag_q[index_s]   <= tag_s;
      end
      if (line_fill_s || line_upd_s) begin
        data_q[index_s] <= line_wdata_s;
      end
    end
  end

  assign rd_data_o    = rd_data_s;
  assign stall_o      = stall_s;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;

endmodule

// File: tb/tb_dcache_wt.sv
// -----------------------------------------------------------------------------
// tb_dcache_wt
//
// Self-checking bench for dcache_wt. It holds a backing memory that answers
// mem_req after a chosen latency. It applies a table of directed operations
// with hand-derived expectations, then a reset-during-fill sequence, then
// random operations checked against a behavioural cache model.
// -----------------------------------------------------------------------------
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wr_data, rd_data, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, stall, mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_wt #(.INDEX_BITS(4)) dut (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .wr_data_i(wr_data),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .rd_data_o(rd_data),
    .stall_o(stall), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack), .hit_count_o(hit_count), .miss_count_o(miss_count)
  );

  // Backing memory seen by the DUT, and a separate copy held by the model.
  logic [31:0] env_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  // Reference cache: one word per line, indexed by word address modulo 16.
  bit          ref_valid [16];
  int unsigned ref_tag   [16];
  logic [31:0] ref_data  [16];
  logic [31:0] ref_hits, ref_misses;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_stall;
    logic [31:0] exp_hits;
    logic [31:0] exp_miss;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h3C5A0F1E;
  endfunction

  function automatic logic [31:0] env_get(input logic [29:0] w);
    if (env_mem.exists(w)) return env_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] ref_get(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  function automatic bit bus_ok(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    return (mem_req === 1'b1) && (mem_we === wr) && (mem_addr === a[31:2]) &&
           (!wr || (mem_wdata === wd));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_ack   = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Apply one operation, act as the backing memory, and check the stall
  // profile, load data, request bus and counters.
  task automatic run_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input int exp_stall, input logic [31:0] exp_h,
                        input logic [31:0] exp_m, input string nm);
    int prof_bad;
    int bus_bad;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wr_data   = wd;
    if (exp_stall == 0) begin
      @(negedge clk);
      chk({nm, ":stall"}, {31'd0, stall}, 32'd0);
      chk({nm, ":rd_data"}, rd_data, exp_rd);
      @(posedge clk);
      #1;
    end else begin
      prof_bad = 0;
      bus_bad  = 0;
      for (int k = 0; k < exp_stall; k++) begin
        @(negedge clk);
        if (stall !== 1'b1 || rd_data !== 32'd0) prof_bad++;
        if (k > 0 && !bus_ok(wr, a, wd)) bus_bad++;
        @(posedge clk);
        #1;
      end
      mem_ack   = 1'b1;
      mem_rdata = mem_we ? 32'hBAD0BAD0 : env_get(mem_addr);
      @(negedge clk);
      if (!bus_ok(wr, a, wd)) bus_bad++;
      if (mem_we === 1'b1) env_mem[mem_addr] = mem_wdata;
      chk({nm, ":stall_profile"}, prof_bad, 32'd0);
      chk({nm, ":req_bus"}, bus_bad, 32'd0);
      chk({nm, ":ack_stall"}, {31'd0, stall}, 32'd0);
      chk({nm, ":ack_rd_data"}, rd_data, exp_rd);
      @(posedge clk);
      #1 mem_ack = 1'b0;
      chk({nm, ":req_clear"}, {31'd0, mem_req}, 32'd0);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk({nm, ":hit_count"}, hit_count, exp_h);
    chk({nm, ":miss_count"}, miss_count, exp_m);
  endtask

  // Behavioural model: returns the expected load data and stall length.
  task automatic model_op(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int lat,
                          output logic [31:0] exp_rd, output int exp_stall);
    int unsigned w, idx, tg;
    w   = a / 4;
    idx = w % 16;
    tg  = a / 64;
    exp_rd    = 32'd0;
    exp_stall = 0;
    if (wr) begin
      ref_mem[w[29:0]] = wd;
      if (ref_valid[idx] && ref_tag[idx] == tg) ref_data[idx] = wd;
      exp_stall = 1 + lat;
    end else if (rd) begin
      if (ref_valid[idx] && ref_tag[idx] == tg) begin
        exp_rd   = ref_data[idx];
        ref_hits = ref_hits + 32'd1;
      end else begin
        ref_misses     = ref_misses + 32'd1;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
        ref_data[idx]  = ref_get(w[29:0]);
        exp_rd         = ref_data[idx];
        exp_stall      = 1 + lat;
      end
    end
  endtask

  initial begin
    logic [31:0] e_rd, a, wd;
    int          e_st, r, lat;

    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_ack   = 1'b0;
    addr      = 32'd0;
    wr_data   = 32'd0;
    mem_rdata = 32'd0;

    env_mem[30'h10]  = 32'hDEADBEEF;
    env_mem[30'h110] = 32'hCAFEF00D;

    // Directed sequence: {rd, wr, addr, wdata, rd_data, stall cycles, hits, misses}
    vecs[0]  = '{1'b1, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 4, 32'd0, 32'd1};
    vecs[1]  = '{1'b1, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 0, 32'd1, 32'd1};
    vecs[2]  = '{1'b0, 1'b1, 32'h40,  32'h12345678, 32'h0,        3, 32'd1, 32'd1};
    vecs[3]  = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h12345678, 0, 32'd2, 32'd1};
    vecs[4]  = '{1'b0, 1'b1, 32'h80,  32'h55AA55AA, 32'h0,        2, 32'd2, 32'd1};
    vecs[5]  = '{1'b1, 1'b0, 32'h80,  32'h0,        32'h55AA55AA, 3, 32'd2, 32'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'h440, 32'h0,        32'hCAFEF00D, 2, 32'd2, 32'd3};
    vecs[7]  = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h12345678, 1, 32'd2, 32'd4};
    vecs[8]  = '{1'b1, 1'b1, 32'h40,  32'hA5A5A5A5, 32'h0,        2, 32'd2, 32'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'h40,  32'h0,        32'hA5A5A5A5, 0, 32'd3, 32'd4};
    vecs[10] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h0,        0, 32'd3, 32'd4};

    // Reset state.
    #3;
    chk("rst:stall", {31'd0, stall}, 32'd0);
    chk("rst:rd_data", rd_data, 32'd0);
    chk("rst:mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst:mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst:mem_addr", {2'd0, mem_addr}, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    chk("rst:hit_count", hit_count, 32'd0);
    chk("rst:miss_count", miss_count, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
             vecs[i].exp_stall, vecs[i].exp_hits, vecs[i].exp_miss,
             $sformatf("vec%0d", i));
    end

    // Reset in the middle of a fill; the late ack must be ignored.
    pulse_reset();
    mem_read = 1'b1;
    addr     = 32'h40;
    @(negedge clk);
    chk("rstfill:req_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rstfill:mem_req_before", {31'd0, mem_req}, 32'd1);
    #1 reset = 1'b1;
    mem_read = 1'b0;
    #1;
    chk("rstfill:mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstfill:stall", {31'd0, stall}, 32'd0);
    chk("rstfill:hit_count", hit_count, 32'd0);
    chk("rstfill:miss_count", miss_count, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("lateack:stall", {31'd0, stall}, 32'd0);
    chk("lateack:rd_data", rd_data, 32'd0);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    chk("lateack:mem_req", {31'd0, mem_req}, 32'd0);
    chk("lateack:miss_count", miss_count, 32'd0);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 32'hA5A5A5A5, 3, 32'd0, 32'd1, "after_rst");

    // Random traffic over a small address pool so hits and conflicts occur.
    pulse_reset();
    env_mem.delete();
    ref_mem.delete();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    ref_hits   = 32'd0;
    ref_misses = 32'd0;
    for (int n = 0; n < 400; n++) begin
      r   = $urandom_range(0, 9);
      lat = $urandom_range(0, 4);
      a   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      wd  = $urandom;
      model_op((r >= 1), (r >= 7), a, wd, lat, e_rd, e_st);
      run_op((r >= 1), (r >= 7), a, wd, e_rd, e_st, ref_hits, ref_misses,
             $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache that replaces the single-cycle data memory at the memory/writeback stage of the pipelined MIPS machine. It takes the registered MW-stage address, store data and MemRead/MemWrite controls, returns load data, and talks to a variable-latency backing memory over a req/ack handshake. It raises `stall` to freeze the whole pipeline, including the DE/MW registers, while a miss or store is outstanding. It also keeps hit and miss counters.

## Interface
- `INDEX_BITS`, default 4: line-index width; the cache holds 2^INDEX_BITS one-word lines.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `addr` in 32: byte address (ALU result). Bits [1:0] are ignored.
- `wr_data` in 32: store data.
- `mem_read` in 1: load request, valid while asserted.
- `mem_write` in 1: store request, valid while asserted.
- `rd_data` out 32: load data.
- `stall` out 1: combinational; when high, the pipeline must hold every register and keep all inputs stable.
- `mem_req` out 1: registered backing-memory request.
- `mem_we` out 1: registered; 1 = write, 0 = read.
- `mem_addr` out 30: registered word address.
- `mem_wdata` out 32: registered write data.
- `mem_rdata` in 32: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: one-cycle completion pulse from the backing memory.
- `hit_count` out 32: number of load hits.
- `miss_count` out 32: number of load misses.

## Operation
- Address split: index = `addr[INDEX_BITS+1:2]`, tag = `addr[31:INDEX_BITS+2]`.
- Each line holds valid, tag and a 32-bit data word.
- A hit requires the line to be valid and its tag to equal the address tag.
- States are IDLE, FILL and WRITE.
- IDLE with `mem_write`:
  - `stall`=1.
  - Next state is WRITE; load `mem_req`=1, `mem_we`=1, `mem_addr`=`addr[31:2]`, `mem_wdata`=`wr_data`.
- IDLE with `mem_read` and a hit:
  - `stall`=0; `rd_data` = line data (combinational, zero extra latency).
  - `hit_count` increments.
- IDLE with `mem_read` and a miss:
  - `stall`=1.
  - Next state is FILL; load `mem_req`=1, `mem_we`=0, `mem_addr`=`addr[31:2]`.
  - `miss_count` increments.
- `mem_read` and `mem_write` both high: the write takes priority and the read is ignored.
- IDLE with neither request: `stall`=0, `rd_data`=0.
- FILL:
  - `stall` = !`mem_ack`.
  - In the `mem_ack` cycle, `rd_data` = `mem_rdata` (bypass).
  - At that edge the line is written with valid=1, tag and `mem_rdata`; `mem_req` clears; state returns to IDLE.
- WRITE:
  - `stall` = !`mem_ack`.
  - At the `mem_ack` edge: if the line hits, its data becomes `wr_data`. On a miss the line is untouched (no allocate). `mem_req` clears; state returns to IDLE.
- `rd_data` is 0 in every cycle not listed above.
- `mem_ack` in IDLE is ignored.
- The counters wrap modulo 2^32. A load hit counts once per cycle in which it completes with `stall`=0. A fill's completion cycle does not count as a hit.

## Timing
- Reset values: state IDLE; all valid bits 0; `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0; `hit_count`, `miss_count` = 0. Combinationally, `stall`=0 and `rd_data`=0.
- Reset asserted mid-FILL or mid-WRITE: everything above takes effect immediately, and any later `mem_ack` is ignored.
- Load hit: 0 stall cycles.
- Load miss: stall from the request cycle through every FILL cycle before the ack (1 + N cycles, where ack arrives N cycles after `mem_req` rises). Data is delivered in the ack cycle.
- Store: same stall profile as a load miss.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from request until the ack edge.
- A load to a just-filled or just-written address in the next cycle hits.

## Test plan
- Reset, then load 0x00000040; backing memory acks 3 cycles after `mem_req` with 0xDEADBEEF. Required: `stall` high for 4 cycles; `rd_data`=0xDEADBEEF in the ack cycle; `miss_count`=1. Reloading 0x40 hits with 0 stall and `hit_count`=1.
- Store 0x12345678 to 0x40 after the fill. Required: `mem_we`=1, `mem_addr`=0x10. After the ack, a load of 0x40 hits and returns 0x12345678.
- Store to uncached 0x80. Required: after the ack, a load of 0x80 misses (no allocate).
- Conflict: fill 0x40, then load 0x440 (same index when INDEX_BITS=4). Required: miss and refill; a subsequent load of 0x40 misses again.
- Assert `reset` during FILL, then deliver `mem_ack`. Required: `mem_req`=0, state IDLE, counters 0, and a load of 0x40 misses.
- `mem_read` and `mem_write` both high for 0x40. Required: a write request is issued, no fill occurs, and `miss_count` is unchanged.
